// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine:
// FSM state encoding and the width of one adder pass.
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/twos_complement_adder.sv
// 4-bit two's-complement adder core with carry in/out; purely combinational.
module twos_complement_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/subtract built on the 4-bit adder: one nibble per cycle, LSB
// first, with the carry held in a register between passes.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic [3:0]       add_x_s, add_y_s, add_sum_s;
    logic             add_cin_s, add_cout_s;
    logic [WIDTH-1:0] res_shift_s;

    twos_complement_adder u_adder (
        .x     (add_x_s),
        .y     (add_y_s),
        .c_in  (add_cin_s),
        .sum   (add_sum_s),
        .c_out (add_cout_s)
    );

    // The new sum nibble enters at the top so the result is aligned after the last pass.
    generate
        if (WIDTH == NIBBLE_W) begin : g_single
            assign res_shift_s = add_sum_s;
        end else begin : g_multi
            assign res_shift_s = {add_sum_s, result_q[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    // Next-state, datapath and output-register logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        add_x_s     = 4'h0;
        add_y_s     = 4'h0;
        add_cin_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: the +1 rides in as the first carry-in.
                    opa_d    = a;
                    opb_d    = sub ? ~b : b;
                    carry_d  = sub;
                    cnt_d    = '0;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            S_RUN: begin
                add_x_s   = opa_q[3:0];
                add_y_s   = opb_q[3:0];
                add_cin_s = carry_q;
                opa_d     = opa_q >> NIBBLE_W;
                opb_d     = opb_q >> NIBBLE_W;
                result_d  = res_shift_s;
                carry_d   = add_cout_s;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                done_d      = 1'b1;
                carry_out_d = carry_q;
                overflow_d  = (sign_a_q == sign_b_q) && (result_q[WIDTH-1] != sign_a_q);
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: 16-bit and 4-bit instances driven
// with directed vectors; a forked monitor checks every done pulse against a queue.
module tb_nibble_serial_addsub;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start16, sub16, start4, sub4;
    logic [15:0] a16, b16;
    logic [3:0]  a4, b4;
    logic        busy16, done16, cout16, ovf16;
    logic        busy4, done4, cout4, ovf4;
    logic [15:0] result16;
    logic [3:0]  result4;

    exp_t exp16_q[$];
    exp_t exp4_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_done16 = 0, n_done4 = 0;
    int   pushed16 = 0, pushed4 = 0;

    nibble_serial_addsub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16),
        .carry_out(cout16), .overflow(ovf16)
    );

    nibble_serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4),
        .carry_out(cout4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && done16) begin
                n_done16++;
                if (exp16_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done16: got done with no pending op");
                end else begin
                    e = exp16_q.pop_front();
                    chk("result16", {16'h0, result16}, {16'h0, e.r});
                    chk("carry16", {31'h0, cout16}, {31'h0, e.c});
                    chk("ovf16", {31'h0, ovf16}, {31'h0, e.v});
                end
            end
            if (!rst && done4) begin
                n_done4++;
                if (exp4_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done4: got done with no pending op");
                end else begin
                    e = exp4_q.pop_front();
                    chk("result4", {28'h0, result4}, {16'h0, e.r});
                    chk("carry4", {31'h0, cout4}, {31'h0, e.c});
                    chk("ovf4", {31'h0, ovf4}, {31'h0, e.v});
                end
            end
        end
    endtask

    // Issue one op, then track busy and the done latency (edges after the start edge).
    task automatic do_op(input bit sel4, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] er, input logic ec,
                         input logic ev, input bit glitch);
        bit got;
        int lat;
        @(negedge clk);
        if (sel4) begin
            a4 = a[3:0]; b4 = b[3:0]; sub4 = s; start4 = 1'b1;
            exp4_q.push_back('{r: er, c: ec, v: ev});
            pushed4++;
        end else begin
            a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
            exp16_q.push_back('{r: er, c: ec, v: ev});
            pushed16++;
        end
        @(posedge clk);
        #1;
        start16 = 1'b0;
        start4  = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            if (glitch && k == 2) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0; start16 = 1'b1;
            end
            @(posedge clk);
            #1;
            start16 = 1'b0;
            chk("busy_during_op", {31'h0, (sel4 ? busy4 : busy16)}, 32'h1);
            if (sel4 ? done4 : done16) begin
                got = 1'b1;
                lat = k;
            end
        end
        chk("done_seen", {31'h0, got}, 32'h1);
        chk("done_latency", lat, sel4 ? 32'd2 : 32'd5);
    endtask

    initial begin
        rst = 1'b1;
        start16 = 1'b0; sub16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
        start4 = 1'b0;  sub4 = 1'b0;  a4 = 4'h0;   b4 = 4'h0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy16}, 32'h0);
        chk("rst_done", {31'h0, done16}, 32'h0);
        chk("rst_result", {16'h0, result16}, 32'h0);
        chk("rst_carry", {31'h0, cout16}, 32'h0);
        chk("rst_ovf", {31'h0, ovf16}, 32'h0);
        rst = 1'b0;

        // Basic add, then done/busy drop one edge after the done cycle.
        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'h0, done16}, 32'h0);
        chk("busy_cleared", {31'h0, busy16}, 32'h0);

        do_op(1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        do_op(1'b0, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op(1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Outputs hold after done.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", {16'h0, result16}, 32'h7FFF);
        chk("hold_ovf", {31'h0, ovf16}, 32'h1);
        chk("hold_carry", {31'h0, cout16}, 32'h1);

        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Second start during RUN must be ignored.
        do_op(1'b0, 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1);

        // Reset at edge 3 of an op abandons it.
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy16}, 32'h0);
        chk("abort_done", {31'h0, done16}, 32'h0);
        chk("abort_result", {16'h0, result16}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        // WIDTH=4 instance.
        do_op(1'b1, 16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b0);
        do_op(1'b1, 16'h0003, 16'h0005, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0);
        do_op(1'b1, 16'h0008, 16'h0001, 1'b1, 16'h0007, 1'b1, 1'b1, 1'b0);

        repeat (10) @(negedge clk);
        chk("done_count16", n_done16, pushed16);
        chk("done_count4", n_done4, pushed4);
        chk("pending16", exp16_q.size(), 32'h0);
        chk("pending4", exp4_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
